instr_mem_fetch: RTL and testbench

- Parametrised, clocked instruction memory for the fetch stage.
- Byte-organised, little-endian storage returns one 32-bit instruction per accepted request.
- Request/response valid/ready handshakes with configurable read latency and backpressure.
- Adds a program-load write port and alignment/range fault reporting, so the core can fetch from a loadable, bounds-checked store.

---
 rtl/instr_mem_pkg.sv | 21 ++
 rtl/instr_mem_fetch_if.sv | 34 +++
 rtl/fetch_pipe_stage.sv | 42 ++++
 rtl/instr_mem_fetch.sv | 107 ++++++++++
 tb/tb_instr_mem_fetch.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants and payload types for the fetch-stage instruction memory.
package instr_mem_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned FAULT_W        = 2;
    localparam int unsigned STRB_W         = INSTR_W / 8;

    // Bit positions inside the fault field.
    localparam int unsigned FAULT_MISALIGN = 0;
    localparam int unsigned FAULT_RANGE    = 1;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] RV32I_NOP = 32'h0000_0013;

    // Per-stage response payload; the address travels separately since its width is a parameter.
    typedef struct packed {
        logic [FAULT_W-1:0] fault;
        logic [INSTR_W-1:0] instr;
    } rsp_payload_t;

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Fetch request/response and program-load bus.
//   master: the core / loader side (drives requests, load writes, rsp_ready)
//   slave : the instruction memory (drives req_ready and the rsp_* fields)
interface instr_mem_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    import instr_mem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_W-1:0]    req_addr;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [INSTR_W-1:0]   rsp_instr;
    logic [ADDR_W-1:0]    rsp_addr;
    logic [FAULT_W-1:0]   rsp_fault;

    logic                 ld_en;
    logic [ADDR_W-1:0]    ld_addr;
    logic [INSTR_W-1:0]   ld_data;
    logic [STRB_W-1:0]    ld_strb;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_strb,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_strb,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

endinterface

// File: rtl/fetch_pipe_stage.sv
// One fetch pipeline stage: valid/addr/payload register that loads when en_i is high.
//   clk, reset : clock, synchronous active-high reset
//   en_i       : shift enable (global advance)
//   *_i / *_o  : stage input from the previous stage, registered output
module fetch_pipe_stage
    import instr_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  rsp_payload_t      payload_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output rsp_payload_t      payload_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    rsp_payload_t      payload_q;

    // Stage register; holds everything while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            payload_q <= '0;
        end else if (en_i) begin
            valid_q   <= valid_i;
            addr_q    <= addr_i;
            payload_q <= payload_i;
        end
    end

    assign valid_o   = valid_q;
    assign addr_o    = addr_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Loadable, bounds-checked byte-organised instruction memory for the fetch stage.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch request/response handshakes and program-load write port
//   busy       : a fetch is in flight or held at the output
module instr_mem_fetch
    import instr_mem_pkg::*;
#(
    parameter int unsigned        DEPTH_BYTES = 2048,
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        LATENCY     = 1,
    parameter logic [INSTR_W-1:0] FAULT_INSTR = RV32I_NOP
) (
    input  logic                clk,
    input  logic                reset,
    instr_mem_fetch_if.slave    bus,
    output logic                busy
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);

    logic [7:0]         mem_q [DEPTH_BYTES];

    logic               advance;
    logic               ready;
    logic               accept;

    logic [FAULT_W-1:0] req_fault;
    logic [IDX_W-1:0]   rd_idx;
    logic [INSTR_W-1:0] rd_word;

    logic [ADDR_W-1:0]  ld_word;
    logic [IDX_W-1:0]   ld_idx;
    logic               ld_hit;

    logic [LATENCY:0]   stg_valid;
    logic [ADDR_W-1:0]  stg_addr    [LATENCY+1];
    rsp_payload_t       stg_payload [LATENCY+1];

    // Handshake: every stage shifts together unless the output is held.
    assign advance = !stg_valid[LATENCY] || bus.rsp_ready;
    assign ready   = advance && !bus.ld_en && !reset;
    assign accept  = bus.req_valid && ready;

    // Full-width range compare so large addresses never alias into the array.
    always_comb begin
        req_fault                 = '0;
        req_fault[FAULT_MISALIGN] = (bus.req_addr[1:0] != 2'b00);
        req_fault[FAULT_RANGE]    = (bus.req_addr > LAST_WORD);
    end

    // Read at accept time; a faulted fetch never forms a memory index.
    always_comb begin
        rd_idx  = '0;
        rd_word = FAULT_INSTR;
        if (req_fault == '0) begin
            rd_idx  = bus.req_addr[IDX_W-1:0];
            rd_word = {mem_q[rd_idx + IDX_W'(3)], mem_q[rd_idx + IDX_W'(2)],
                       mem_q[rd_idx + IDX_W'(1)], mem_q[rd_idx]};
        end
    end

    // Load port: low address bits are masked, out-of-range words dropped.
    assign ld_word = bus.ld_addr & ~ADDR_W'(3);
    assign ld_hit  = bus.ld_en && (ld_word <= LAST_WORD);
    assign ld_idx  = ld_word[IDX_W-1:0];

    // Byte storage; not affected by reset.
    always_ff @(posedge clk) begin
        if (ld_hit) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (bus.ld_strb[i]) begin
                    mem_q[ld_idx + IDX_W'(i)] <= bus.ld_data[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 input is the request being accepted this cycle.
    assign stg_valid[0]   = accept;
    assign stg_addr[0]    = bus.req_addr;
    assign stg_payload[0] = '{fault: req_fault, instr: rd_word};

    for (genvar g = 0; g < int'(LATENCY); g++) begin : g_stage
        fetch_pipe_stage #(
            .ADDR_W    (ADDR_W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en_i      (advance),
            .valid_i   (stg_valid[g]),
            .addr_i    (stg_addr[g]),
            .payload_i (stg_payload[g]),
            .valid_o   (stg_valid[g+1]),
            .addr_o    (stg_addr[g+1]),
            .payload_o (stg_payload[g+1])
        );
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = stg_valid[LATENCY];
    assign bus.rsp_addr  = stg_addr[LATENCY];
    assign bus.rsp_instr = stg_payload[LATENCY].instr;
    assign bus.rsp_fault = stg_payload[LATENCY].fault;
    assign busy          = |stg_valid[LATENCY:1];

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Randomised and directed self-checking bench for instr_mem_fetch.
module tb_instr_mem_fetch;

    localparam int unsigned DEPTH   = 2048;
    localparam int unsigned LAT     = 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] LASTW   = 32'(DEPTH - 4);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    instr_mem_fetch_if #(.ADDR_W(32)) bus ();

    instr_mem_fetch #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (32),
        .LATENCY     (LAT),
        .FAULT_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
        int          rem;
    } exp_t;

    logic [7:0] ref_mem [DEPTH];
    exp_t       q [$];

    int n_chk  = 0;
    int n_fail = 0;

    // Values captured by the last tick.
    logic        s_ready, s_acc, s_hs;
    logic [31:0] hs_addr, hs_instr;
    logic [1:0]  hs_fault;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        e.addr  = a;
        e.fault = {a > LASTW, a[1:0] != 2'b00};
        e.rem   = int'(LAT) - 1;
        if (e.fault != 2'b00) e.instr = NOP;
        else e.instr = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        return e;
    endfunction

    // One clock: sample and check at the falling edge, update the model at the rising edge.
    task automatic tick();
        logic adv;
        exp_t e;
        @(negedge clk);
        adv     = !bus.rsp_valid || bus.rsp_ready;
        s_ready = bus.req_ready;
        s_acc   = bus.req_valid && bus.req_ready;
        s_hs    = bus.rsp_valid && bus.rsp_ready;
        hs_addr = bus.rsp_addr; hs_instr = bus.rsp_instr; hs_fault = bus.rsp_fault;
        chk("req_ready", 64'(bus.req_ready), 64'(adv && !bus.ld_en && !reset));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'((q.size() != 0) ? (q[0].rem == 0) : 1'b0));
        if (bus.rsp_valid && q.size() != 0) begin
            chk("rsp_addr", 64'(bus.rsp_addr), 64'(q[0].addr));
            chk("rsp_instr", 64'(bus.rsp_instr), 64'(q[0].instr));
            chk("rsp_fault", 64'(bus.rsp_fault), 64'(q[0].fault));
        end
        e = model_fetch(bus.req_addr);
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (s_hs && q.size() != 0) void'(q.pop_front());
            if (adv) foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
            if (s_acc) q.push_back(e);
        end
        if (bus.ld_en) begin
            logic [31:0] wa;
            wa = bus.ld_addr & 32'hFFFF_FFFC;
            if (wa <= LASTW)
                for (int i = 0; i < 4; i++)
                    if (bus.ld_strb[i]) ref_mem[wa + 32'(i)] = bus.ld_data[8*i +: 8];
        end
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d; bus.ld_strb = s;
        tick();
        bus.ld_en = 1'b0;
    endtask

    // Wait (bounded) for the next response handshake; returns cycles waited.
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_hs && n < 12);
        if (!s_hs) chk("rsp_timeout", 64'(0), 64'(1));
    endtask

    task automatic fetch_one(input string tag, input logic [31:0] a,
                             input logic [31:0] ei, input logic [1:0] ef);
        int n;
        bus.req_valid = 1'b1; bus.req_addr = a;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_acc && n < 12);
        bus.req_valid = 1'b0;
        if (!s_acc) chk({tag, "_accept_timeout"}, 64'(0), 64'(1));
        wait_rsp(n);
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        chk({tag, "_instr"}, 64'(hs_instr), 64'(ei));
        chk({tag, "_fault"}, 64'(hs_fault), 64'(ef));
        chk({tag, "_addr"}, 64'(hs_addr), 64'(a));
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    initial begin
        int n;
        logic [31:0] seen [$];
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_strb = '0;

        // Reset state.
        tick(); tick();
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset_rsp_instr", 64'(bus.rsp_instr), 64'(0));
        chk("reset_rsp_addr", 64'(bus.rsp_addr), 64'(0));
        chk("reset_rsp_fault", 64'(bus.rsp_fault), 64'(0));
        chk("reset_req_ready", 64'(s_ready), 64'(0));
        reset = 1'b0;

        // Fill the whole store so every fetch has a known expected value.
        for (int w = 0; w < int'(DEPTH / 4); w++) load(32'(w * 4), $urandom, 4'hF);

        load(32'h10, 32'hDEADBEEF, 4'hF);
        fetch_one("basic", 32'h10, 32'hDEADBEEF, 2'b00);
        fetch_one("misalign", 32'h12, NOP, 2'b01);
        fetch_one("range", 32'h800, NOP, 2'b10);
        fetch_one("both", 32'hFFFF_FFFF, NOP, 2'b11);
        fetch_one("last", 32'h7FC, ref_word(32'h7FC), 2'b00);

        // Back-to-back with a 3-cycle stall after the first response.
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0; tick(); if (s_hs) seen.push_back(hs_addr);
        bus.req_addr = 32'h4; tick(); if (s_hs) seen.push_back(hs_addr);
        bus.req_addr = 32'h8; tick(); if (s_hs) seen.push_back(hs_addr);
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req_ready", 64'(s_ready), 64'(0));
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (s_hs) seen.push_back(hs_addr); end
        chk("b2b_count", 64'(seen.size()), 64'(3));
        for (int i = 0; i < 3 && i < seen.size(); i++) chk("b2b_order", 64'(seen[i]), 64'(i * 4));

        // Load has priority over fetch.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0;
        load(32'h20, 32'h11223344, 4'hF);
        chk("ld_blocks_ready", 64'(s_ready), 64'(0));
        bus.req_valid = 1'b0;
        load(32'h21, 32'h0000AB00, 4'b0010);
        fetch_one("partial", 32'h20, 32'h1122AB44, 2'b00);

        // Load hitting a word while its fetch is in flight.
        load(32'h30, 32'hAAAA5555, 4'hF);
        bus.req_valid = 1'b1; bus.req_addr = 32'h30; tick();
        bus.req_valid = 1'b0;
        load(32'h30, 32'h12345678, 4'hF);
        wait_rsp(n);
        chk("stale_instr", 64'(hs_instr), 64'(32'hAAAA5555));

        // Reset with two fetches in flight.
        bus.req_valid = 1'b1; bus.req_addr = 32'h10; tick();
        bus.req_addr = 32'h14; tick();
        bus.req_valid = 1'b0; reset = 1'b1; tick();
        reset = 1'b0; tick();
        chk("rst_flush_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_flush_busy", 64'(busy), 64'(0));
        n = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (s_hs) n++; end
        chk("rst_no_stale", 64'(n), 64'(0));
        fetch_one("retained", 32'h10, 32'hDEADBEEF, 2'b00);

        // Randomised traffic checked against the queue model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            bus.req_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            case (r)
                0: bus.req_addr = {21'd0, 9'($urandom), 2'($urandom_range(1, 3))};
                1: bus.req_addr = $urandom_range(32'h7FD, 32'hFFFF_FFFF);
                2: bus.req_addr = ($urandom_range(0, 1) != 0) ? 32'h7FC : 32'h800;
                default: bus.req_addr = {21'd0, 9'($urandom), 2'b00};
            endcase
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            bus.ld_en     = ($urandom_range(0, 9) == 0);
            bus.ld_addr   = ($urandom_range(0, 4) == 0) ? $urandom : {21'd0, 11'($urandom)};
            bus.ld_data   = $urandom;
            bus.ld_strb   = 4'($urandom);
            reset         = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; bus.req_valid = 1'b0; bus.ld_en = 1'b0; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("drain_busy", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
